// File: rtl/exu_pkg.sv
// ---------------------------------------------------------------------------
// exu_pkg
// Shared definitions for the EX-stage issue controller.
//   XLEN        default datapath width
//   ALUOP_*     4-bit ALU opcodes driven on alu_op
//   BR_*        3-bit branch/jump types carried with each instruction
//   exu_state_e issue-slot occupancy (IDLE = empty, FULL = holds one instr)
//   is_cond_br  true for the six compare-and-branch types
// ---------------------------------------------------------------------------
package exu_pkg;

   localparam int XLEN = 32;

   localparam logic [3:0] ALUOP_ADD  = 4'b0000;
   localparam logic [3:0] ALUOP_SUB  = 4'b0001;
   localparam logic [3:0] ALUOP_OR   = 4'b0010;
   localparam logic [3:0] ALUOP_SLT  = 4'b0011;
   localparam logic [3:0] ALUOP_SRL  = 4'b0100;
   localparam logic [3:0] ALUOP_SRA  = 4'b0101;
   localparam logic [3:0] ALUOP_SLL  = 4'b0110;
   localparam logic [3:0] ALUOP_AND  = 4'b0111;
   localparam logic [3:0] ALUOP_XOR  = 4'b1000;
   localparam logic [3:0] ALUOP_SLTU = 4'b1001;

   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_BEQ  = 3'b001;
   localparam logic [2:0] BR_BNE  = 3'b010;
   localparam logic [2:0] BR_BLT  = 3'b011;
   localparam logic [2:0] BR_BGE  = 3'b100;
   localparam logic [2:0] BR_BLTU = 3'b101;
   localparam logic [2:0] BR_BGEU = 3'b110;
   localparam logic [2:0] BR_JUMP = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FULL = 1'b1
   } exu_state_e;

   function automatic logic is_cond_br(input logic [2:0] br_type);
      return (br_type != BR_NONE) && (br_type != BR_JUMP);
   endfunction

endpackage

// File: rtl/exu_branch_cond.sv
// ---------------------------------------------------------------------------
// exu_branch_cond
// Purely combinational branch resolution from the flags of rs1 - rs2.
//   br_type  in  branch/jump type (BR_*)
//   res_msb  in  sign bit of the subtract result
//   of       in  signed overflow of the subtract
//   cf       in  carry-out of the subtract (1 = no borrow, rs1 >= rs2 unsigned)
//   zf       in  subtract result is zero
//   taken    out branch condition holds (always 1 for a jump, 0 for none)
// ---------------------------------------------------------------------------
module exu_branch_cond
   import exu_pkg::*;
(
   input  logic [2:0] br_type,
   input  logic       res_msb,
   input  logic       of,
   input  logic       cf,
   input  logic       zf,
   output logic       taken
);

   // Signed less-than: the sign of the difference is wrong exactly when it overflowed.
   logic lt_signed;
   assign lt_signed = res_msb ^ of;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      taken = 1'b0;
      unique case (br_type)
         BR_BEQ:  taken = zf;
         BR_BNE:  taken = !zf;
         BR_BLT:  taken = lt_signed;
         BR_BGE:  taken = !lt_signed;
         BR_BLTU: taken = !cf;
         BR_BGEU: taken = cf;
         BR_JUMP: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/exu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// exu_issue_ctrl
// EX-stage issue controller: a single registered slot between the IDU and
// WBU/IFU. Drives the external single-cycle ALU from the slot and turns its
// result/flags into writeback data and a branch/jump redirect.
//   clk, rst_n           clock, asynchronous active-low reset
//   id_valid/id_ready    IDU handshake; id_pc, id_rs1_data, id_rs2_data,
//                        id_imm, id_asel, id_bsel, id_aluop, id_br_type payload
//   alu_a/alu_b/alu_op   operands and opcode to the ALU
//   alu_result, alu_of,
//   alu_cf, alu_zf       ALU result and flags
//   flush                drop the in-flight instruction, refuse new ones
//   ex_valid/ex_ready    downstream handshake; ex_result, ex_redirect,
//                        ex_target payload (meaningful only while ex_valid)
// ---------------------------------------------------------------------------
module exu_issue_ctrl #(
   parameter int               XLEN          = exu_pkg::XLEN,
   parameter logic [XLEN-1:0]  RESET_PC_LINK = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   output logic            id_ready,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic            id_asel,
   input  logic            id_bsel,
   input  logic [3:0]      id_aluop,
   input  logic [2:0]      id_br_type,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      alu_op,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_of,
   input  logic            alu_cf,
   input  logic            alu_zf,
   input  logic            flush,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_result,
   output logic            ex_redirect,
   output logic [XLEN-1:0] ex_target
);

   import exu_pkg::*;

   exu_state_e      state_q, state_d;
   logic            accept;

   logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;
   logic            asel_q, bsel_q;
   logic [3:0]      aluop_q;
   logic [2:0]      br_q;

   logic            cond_br;
   logic            taken;
   logic [XLEN-1:0] br_target;
   logic [XLEN-1:0] link_pc;

   // The slot can take a new instruction when empty or when it is being
   // drained this cycle; a flush refuses everything.
   assign id_ready = !flush && ((state_q == ST_IDLE) || ex_ready);
   assign accept   = id_valid && id_ready;
   assign ex_valid = (state_q == ST_FULL);

   always_comb begin
      state_d = state_q;
      if (flush)
         state_d = ST_IDLE;
      else if (accept)
         state_d = ST_FULL;          // covers both fill and same-edge refill
      else if ((state_q == ST_FULL) && ex_ready)
         state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the payload registers are reset too, because alu_a/alu_b/alu_op
      // are driven straight from them and must read zero as soon as rst_n falls.
      if (!rst_n) begin
         pc_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         imm_q   <= '0;
         asel_q  <= 1'b0;
         bsel_q  <= 1'b0;
         aluop_q <= ALUOP_ADD;
         br_q    <= BR_NONE;
      end else if (accept) begin
         pc_q    <= id_pc;
         rs1_q   <= id_rs1_data;
         rs2_q   <= id_rs2_data;
         imm_q   <= id_imm;
         asel_q  <= id_asel;
         bsel_q  <= id_bsel;
         aluop_q <= id_aluop;
         br_q    <= id_br_type;
      end
   end

   // Conditional branches borrow the ALU for rs1 - rs2 whatever the decoder
   // put in aluop/asel/bsel; the flags then decide the branch.
   assign cond_br = is_cond_br(br_q);

   always_comb begin
      alu_a  = asel_q ? pc_q  : rs1_q;
      alu_b  = bsel_q ? imm_q : rs2_q;
      alu_op = aluop_q;
      if (cond_br) begin
         alu_a  = rs1_q;
         alu_b  = rs2_q;
         alu_op = ALUOP_SUB;
      end
   end

   exu_branch_cond u_branch_cond (
      .br_type (br_q),
      .res_msb (alu_result[XLEN-1]),
      .of      (alu_of),
      .cf      (alu_cf),
      .zf      (alu_zf),
      .taken   (taken)
   );

   // Dedicated adders: the ALU is busy with the compare (branch) or the
   // target computation (jump), so pc + imm and pc + 4 are formed here.
   assign br_target = pc_q + imm_q;
   assign link_pc   = pc_q + XLEN'(4);

   // Outputs are held at their reset values whenever the slot is empty.
   always_comb begin
      ex_redirect = 1'b0;
      ex_target   = '0;
      ex_result   = RESET_PC_LINK;
      if (ex_valid) begin
         ex_redirect = taken;
         if (br_q == BR_JUMP) begin
            ex_target = {alu_result[XLEN-1:1], 1'b0};
            ex_result = link_pc;
         end else if (cond_br) begin
            ex_target = br_target;
            ex_result = '0;
         end else begin
            ex_result = alu_result;
         end
      end
   end

endmodule

// File: tb/tb_exu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exu_issue_ctrl
// Directed bench for exu_issue_ctrl. A behavioural single-cycle ALU closes
// the loop on alu_a/alu_b/alu_op; every expected value is a hand-computed
// constant. Inputs change #1 after a rising edge and outputs are sampled
// there as well, away from the active edge.
// ---------------------------------------------------------------------------
module tb_exu_issue_ctrl;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic        id_asel, id_bsel;
   logic [3:0]  id_aluop;
   logic [2:0]  id_br_type;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_op;
   logic [31:0] alu_result;
   logic        alu_of, alu_cf, alu_zf;
   logic        flush;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_result;
   logic        ex_redirect;
   logic [31:0] ex_target;

   int errors = 0;
   int checks = 0;

   exu_issue_ctrl #(.XLEN(32), .RESET_PC_LINK(32'h0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_pc       (id_pc),
      .id_rs1_data (id_rs1_data),
      .id_rs2_data (id_rs2_data),
      .id_imm      (id_imm),
      .id_asel     (id_asel),
      .id_bsel     (id_bsel),
      .id_aluop    (id_aluop),
      .id_br_type  (id_br_type),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_op      (alu_op),
      .alu_result  (alu_result),
      .alu_of      (alu_of),
      .alu_cf      (alu_cf),
      .alu_zf      (alu_zf),
      .flush       (flush),
      .ex_valid    (ex_valid),
      .ex_ready    (ex_ready),
      .ex_result   (ex_result),
      .ex_redirect (ex_redirect),
      .ex_target   (ex_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-cycle ALU.
   logic [32:0] alu_sum;
   always_comb begin
      alu_sum    = 33'd0;
      alu_result = 32'd0;
      alu_of     = 1'b0;
      alu_cf     = 1'b0;
      case (alu_op)
         4'b0000: begin
            alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
            alu_result = alu_sum[31:0];
            alu_cf     = alu_sum[32];
            alu_of     = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
         end
         4'b0001: begin
            alu_sum    = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
            alu_result = alu_sum[31:0];
            alu_cf     = alu_sum[32];
            alu_of     = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
         end
         4'b0010: alu_result = alu_a | alu_b;
         4'b0011: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
         4'b0100: alu_result = alu_a >> alu_b[4:0];
         4'b0101: alu_result = $signed(alu_a) >>> alu_b[4:0];
         4'b0110: alu_result = alu_a << alu_b[4:0];
         4'b0111: alu_result = alu_a & alu_b;
         4'b1000: alu_result = alu_a ^ alu_b;
         4'b1001: alu_result = {31'd0, alu_a < alu_b};
         default: alu_result = 32'd0;
      endcase
      alu_zf = (alu_result == 32'd0);
   end

   // Global watchdog: the run is a fixed number of cycles, so this only
   // fires if something stalls the initial block.
   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   task automatic issue(input logic [31:0] pc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm,
                        input logic asel, input logic bsel,
                        input logic [3:0] aluop, input logic [2:0] br);
      id_valid    = 1'b1;
      id_pc       = pc;
      id_rs1_data = rs1;
      id_rs2_data = rs2;
      id_imm      = imm;
      id_asel     = asel;
      id_bsel     = bsel;
      id_aluop    = aluop;
      id_br_type  = br;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (ex_valid !== 1'b0)        begin errors++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
      checks++; if (ex_redirect !== 1'b0)     begin errors++; $display("FAIL reset_ex_redirect: got %b want 0", ex_redirect); end
      checks++; if (ex_target !== 32'h0)      begin errors++; $display("FAIL reset_ex_target: got %h want 0", ex_target); end
      checks++; if (ex_result !== 32'h0)      begin errors++; $display("FAIL reset_ex_result: got %h want 0", ex_result); end
      checks++; if (alu_a !== 32'h0)          begin errors++; $display("FAIL reset_alu_a: got %h want 0", alu_a); end
      checks++; if (alu_b !== 32'h0)          begin errors++; $display("FAIL reset_alu_b: got %h want 0", alu_b); end
      checks++; if (alu_op !== 4'h0)          begin errors++; $display("FAIL reset_alu_op: got %h want 0", alu_op); end
      checks++; if (id_ready !== 1'b1)        begin errors++; $display("FAIL reset_id_ready: got %b want 1", id_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++; if (ex_valid !== 1'b0)        begin errors++; $display("FAIL post_reset_idle: got %b want 0", ex_valid); end
   endtask

   task automatic test_add();
      ex_ready = 1'b1;
      issue(32'h0000_1000, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 4'b0000, 3'b000);
      tick();
      id_valid = 1'b0;
      checks++; if (ex_valid !== 1'b1)        begin errors++; $display("FAIL add_valid: got %b want 1", ex_valid); end
      checks++; if (alu_a !== 32'd5)          begin errors++; $display("FAIL add_alu_a: got %h want 5", alu_a); end
      checks++; if (alu_b !== 32'd7)          begin errors++; $display("FAIL add_alu_b: got %h want 7", alu_b); end
      checks++; if (ex_result !== 32'd12)     begin errors++; $display("FAIL add_result: got %h want c", ex_result); end
      checks++; if (ex_redirect !== 1'b0)     begin errors++; $display("FAIL add_redirect: got %b want 0", ex_redirect); end
      tick();
      checks++; if (ex_valid !== 1'b0)        begin errors++; $display("FAIL add_drain: got %b want 0", ex_valid); end
      // pc-relative immediate form: pc + imm through asel/bsel
      issue(32'h0000_2000, 32'd1, 32'd2, 32'h0000_0040, 1'b1, 1'b1, 4'b0000, 3'b000);
      tick();
      id_valid = 1'b0;
      checks++; if (ex_result !== 32'h0000_2040) begin errors++; $display("FAIL auipc_result: got %h want 00002040", ex_result); end
      tick();
   endtask

   task automatic test_beq();
      // aluop/asel/bsel set to non-sub values to confirm the branch override
      issue(32'h8000_0010, 32'd3, 32'd3, 32'hFFFF_FFF0, 1'b1, 1'b1, 4'b0010, 3'b001);
      tick();
      id_valid = 1'b0;
      checks++; if (alu_op !== 4'b0001)          begin errors++; $display("FAIL beq_alu_op: got %h want 1", alu_op); end
      checks++; if (alu_a !== 32'd3)             begin errors++; $display("FAIL beq_alu_a: got %h want 3", alu_a); end
      checks++; if (alu_b !== 32'd3)             begin errors++; $display("FAIL beq_alu_b: got %h want 3", alu_b); end
      checks++; if (ex_redirect !== 1'b1)        begin errors++; $display("FAIL beq_redirect: got %b want 1", ex_redirect); end
      checks++; if (ex_target !== 32'h8000_0000) begin errors++; $display("FAIL beq_target: got %h want 80000000", ex_target); end
      checks++; if (ex_result !== 32'h0)         begin errors++; $display("FAIL beq_result: got %h want 0", ex_result); end
      tick();
      checks++; if (ex_redirect !== 1'b0)        begin errors++; $display("FAIL beq_redirect_drop: got %b want 0", ex_redirect); end
   endtask

   task automatic test_compares();
      // rs1 = -1 / 0xFFFFFFFF, rs2 = 1: unsigned greater, signed less.
      logic [2:0] br_seq  [5] = '{3'b101, 3'b011, 3'b100, 3'b110, 3'b001};
      logic       exp_red [5] = '{1'b0,   1'b1,   1'b0,   1'b1,   1'b0};
      for (int i = 0; i < 5; i++) begin
         issue(32'h0000_0100, 32'hFFFF_FFFF, 32'd1, 32'h0000_0020, 1'b0, 1'b0, 4'b0000, br_seq[i]);
         tick();
         checks++; if (ex_redirect !== exp_red[i]) begin errors++; $display("FAIL cmp_br%0d_redirect: got %b want %b", br_seq[i], ex_redirect, exp_red[i]); end
         checks++; if (ex_valid !== 1'b1)          begin errors++; $display("FAIL cmp_br%0d_valid: got %b want 1", br_seq[i], ex_valid); end
      end
      id_valid = 1'b0;
      tick();
      // bne taken with the target wrapping past 2^32
      issue(32'hFFFF_FFF0, 32'd1, 32'd2, 32'h0000_0020, 1'b0, 1'b0, 4'b0000, 3'b010);
      tick();
      id_valid = 1'b0;
      checks++; if (ex_redirect !== 1'b1)        begin errors++; $display("FAIL bne_redirect: got %b want 1", ex_redirect); end
      checks++; if (ex_target !== 32'h0000_0010) begin errors++; $display("FAIL bne_target_wrap: got %h want 00000010", ex_target); end
      tick();
   endtask

   task automatic test_jump();
      issue(32'h8000_0100, 32'h8000_1003, 32'h0, 32'h0, 1'b0, 1'b1, 4'b0000, 3'b111);
      tick();
      id_valid = 1'b0;
      checks++; if (ex_target !== 32'h8000_1002) begin errors++; $display("FAIL jalr_target: got %h want 80001002", ex_target); end
      checks++; if (ex_result !== 32'h8000_0104) begin errors++; $display("FAIL jalr_link: got %h want 80000104", ex_result); end
      checks++; if (ex_redirect !== 1'b1)        begin errors++; $display("FAIL jalr_redirect: got %b want 1", ex_redirect); end
      tick();
      // jal at the top of the address space: link wraps to 0
      issue(32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0000_0008, 1'b1, 1'b1, 4'b0000, 3'b111);
      tick();
      id_valid = 1'b0;
      checks++; if (ex_target !== 32'h0000_0004) begin errors++; $display("FAIL jal_target: got %h want 00000004", ex_target); end
      checks++; if (ex_result !== 32'h0)         begin errors++; $display("FAIL jal_link_wrap: got %h want 0", ex_result); end
      tick();
   endtask

   task automatic test_back_to_back();
      ex_ready = 1'b1;
      issue(32'h0, 32'd1, 32'd2, 32'h0, 1'b0, 1'b0, 4'b0000, 3'b000);
      tick();
      ex_ready = 1'b0;
      issue(32'h0, 32'd10, 32'd20, 32'h0, 1'b0, 1'b0, 4'b0000, 3'b000);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (id_ready !== 1'b0)    begin errors++; $display("FAIL bp%0d_id_ready: got %b want 0", i, id_ready); end
         checks++; if (ex_valid !== 1'b1)    begin errors++; $display("FAIL bp%0d_valid: got %b want 1", i, ex_valid); end
         checks++; if (ex_result !== 32'd3)  begin errors++; $display("FAIL bp%0d_result: got %h want 3", i, ex_result); end
         checks++; if (alu_a !== 32'd1)      begin errors++; $display("FAIL bp%0d_alu_a: got %h want 1", i, alu_a); end
         tick();
      end
      ex_ready = 1'b1;
      #1;
      checks++; if (id_ready !== 1'b1)       begin errors++; $display("FAIL refill_id_ready: got %b want 1", id_ready); end
      tick();
      id_valid = 1'b0;
      checks++; if (ex_valid !== 1'b1)       begin errors++; $display("FAIL refill_valid: got %b want 1", ex_valid); end
      checks++; if (ex_result !== 32'd30)    begin errors++; $display("FAIL refill_result: got %h want 1e", ex_result); end
      tick();
      checks++; if (ex_valid !== 1'b0)       begin errors++; $display("FAIL refill_drain: got %b want 0", ex_valid); end
   endtask

   task automatic test_flush();
      ex_ready = 1'b1;
      issue(32'h0, 32'd4, 32'd4, 32'h0, 1'b0, 1'b0, 4'b0000, 3'b000);
      tick();
      flush = 1'b1;
      issue(32'h0, 32'd9, 32'd9, 32'h0, 1'b0, 1'b0, 4'b0000, 3'b000);
      #1;
      checks++; if (id_ready !== 1'b0)       begin errors++; $display("FAIL flush_id_ready: got %b want 0", id_ready); end
      checks++; if (ex_valid !== 1'b1)       begin errors++; $display("FAIL flush_cycle_valid: got %b want 1", ex_valid); end
      tick();
      flush    = 1'b0;
      id_valid = 1'b0;
      checks++; if (ex_valid !== 1'b0)       begin errors++; $display("FAIL flush_next_valid: got %b want 0", ex_valid); end
      checks++; if (alu_a !== 32'd4)         begin errors++; $display("FAIL flush_not_taken: got %h want 4", alu_a); end
      tick();
      checks++; if (ex_valid !== 1'b0)       begin errors++; $display("FAIL flush_stays_idle: got %b want 0", ex_valid); end
   endtask

   task automatic test_async_reset();
      ex_ready = 1'b1;
      issue(32'h0, 32'h0000_00F0, 32'h0000_003C, 32'h0, 1'b0, 1'b0, 4'b0111, 3'b000);
      tick();
      id_valid = 1'b0;
      checks++; if (alu_op !== 4'b0111)      begin errors++; $display("FAIL pre_rst_alu_op: got %h want 7", alu_op); end
      checks++; if (ex_result !== 32'h30)    begin errors++; $display("FAIL pre_rst_and: got %h want 30", ex_result); end
      ex_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (ex_valid !== 1'b0)       begin errors++; $display("FAIL async_rst_valid: got %b want 0", ex_valid); end
      checks++; if (alu_op !== 4'h0)         begin errors++; $display("FAIL async_rst_alu_op: got %h want 0", alu_op); end
      checks++; if (alu_a !== 32'h0)         begin errors++; $display("FAIL async_rst_alu_a: got %h want 0", alu_a); end
      @(negedge clk);
      rst_n    = 1'b1;
      ex_ready = 1'b1;
      tick();
      checks++; if (ex_valid !== 1'b0)       begin errors++; $display("FAIL post_rst_no_output: got %b want 0", ex_valid); end
   endtask

   initial begin
      rst_n       = 1'b0;
      id_valid    = 1'b0;
      id_pc       = '0;
      id_rs1_data = '0;
      id_rs2_data = '0;
      id_imm      = '0;
      id_asel     = 1'b0;
      id_bsel     = 1'b0;
      id_aluop    = '0;
      id_br_type  = '0;
      flush       = 1'b0;
      ex_ready    = 1'b0;

      test_reset();
      test_add();
      test_beq();
      test_compares();
      test_jump();
      test_back_to_back();
      test_flush();
      test_async_reset();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/exu_issue_ctrl.md
Name: exu_issue_ctrl

Overview:
- EX-stage issue controller. Accepts decoded instructions from the IDU over a valid/ready handshake and registers them.
- Drives the operand and opcode ports of the single-cycle ALU, then consumes the ALU result and flags.
- Produces the writeback value and the branch/jump redirect toward WBU/IFU over a second valid/ready handshake.
- Fully pipelined: one instruction in flight, 1-cycle latency, back-to-back throughput.

Parameters:
- XLEN, 32, datapath width
- RESET_PC_LINK, 0, reset value of ex_result

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  IDU has an instruction
- id_ready  out  1  this block can accept
- id_pc  in  32  instruction PC
- id_rs1_data  in  32  rs1 value
- id_rs2_data  in  32  rs2 value
- id_imm  in  32  sign-extended immediate
- id_asel  in  1  ALU A source: 0 = rs1, 1 = pc
- id_bsel  in  1  ALU B source: 0 = rs2, 1 = imm
- id_aluop  in  4  ALU opcode (0000 add, 0001 sub, 0010 or, 0011 slt, 0100 srl, 0101 sra, 0110 sll, 0111 and, 1000 xor, 1001 sltu)
- id_br_type  in  3  000 none, 001 beq, 010 bne, 011 blt, 100 bge, 101 bltu, 110 bgeu, 111 jump
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_op  out  4  ALU opcode
- alu_result  in  32  ALU result
- alu_of  in  1  ALU signed overflow
- alu_cf  in  1  ALU carry-out (1 = no borrow on subtract)
- alu_zf  in  1  ALU result-is-zero
- flush  in  1  kill the in-flight instruction
- ex_valid  out  1  result available
- ex_ready  in  1  downstream accepts
- ex_result  out  32  writeback data
- ex_redirect  out  1  taken branch/jump
- ex_target  out  32  redirect PC

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE
  - ex_valid = 0, ex_redirect = 0, ex_target = 0, ex_result = RESET_PC_LINK
  - alu_a = 0, alu_b = 0, alu_op = 0000
  - all pipeline registers cleared
- FSM states: IDLE (empty), FULL (holds an instruction).
- id_ready = (state == IDLE) || ex_ready. id_ready is forced to 0 while flush = 1.
- Accept: id_valid && id_ready on a rising edge registers pc, rs1, rs2, imm, asel, bsel, aluop and br_type; the next state is FULL.
- FULL with ex_ready && !id_valid: next state is IDLE.
- FULL with ex_ready && id_valid: stays FULL and loads the new instruction on the same edge (no bubble).
- FULL with !ex_ready: all registers hold; outputs stay stable until the transfer happens.
- ALU drive, combinational from the registers:
  - alu_a = asel ? pc : rs1
  - alu_b = bsel ? imm : rs2
  - alu_op = aluop
  - Exception: for br_type 001–110, alu_a = rs1, alu_b = rs2, alu_op = 0001 (sub), regardless of aluop/asel/bsel.
- ex_valid = (state == FULL). Latency from accept to ex_valid is 1 cycle.
- Branch condition, from the subtract flags:
  - beq = zf; bne = !zf
  - blt = result[31] ^ of; bge = !(result[31] ^ of)
  - bltu = !cf; bgeu = cf
- Redirect and target:
  - Conditional branch: ex_target = pc + imm using an internal 32-bit adder (wraps mod 2^32, no carry out).
  - Jump (111): ex_redirect = 1; ex_target = alu_result with bit 0 cleared. IDU sets asel for jal vs jalr.
  - ex_redirect = ex_valid && condition.
- ex_result:
  - jump: pc + 4 (wraps mod 2^32)
  - conditional branch: 0
  - otherwise: alu_result
- Flush:
  - Synchronous. Next state is IDLE; any concurrent id_valid is not accepted.
  - ex_valid stays 1 in the flush cycle if state was FULL, but downstream ignores it.
  - flush wins over the ex_ready/id_valid refill.
- Reset mid-operation drops the held instruction; there is no partial output afterwards.
- ex_redirect and ex_target are meaningful only while ex_valid = 1. Each is asserted for exactly the cycles of one handshake.

Decomposition:
- Shared package exu_pkg:
  - ALUOP_* 4-bit constants (add, sub, or, slt, srl, sra, sll, and, xor, sltu)
  - BR_* 3-bit constants
  - XLEN
- One sub-module, exu_branch_cond: combinational; inputs br_type, result[31], of, cf, zf; output taken.

Test Plan:
- add: rs1 = 5, rs2 = 7, asel = 0, bsel = 0, aluop = 0000, ex_ready = 1 → one cycle later ex_valid = 1, alu_a = 5, alu_b = 7, ex_result = 12, ex_redirect = 0.
- beq taken: pc = 0x80000010, imm = 0xFFFFFFF0, rs1 = rs2 = 3, br_type = 001 → alu_op = 0001, ex_redirect = 1, ex_target = 0x80000000, ex_result = 0.
- bltu vs blt: rs1 = 0xFFFFFFFF, rs2 = 1. bltu → redirect 0; blt → redirect 1.
- jump: pc = 0x80000100, rs1 = 0x80001003, imm = 0, asel = 0, bsel = 1, br_type = 111 → ex_target = 0x80001002, ex_result = 0x80000104, ex_redirect = 1.
- Backpressure/refill: ex_ready = 0 for 3 cycles with id_valid held → id_ready = 0 and outputs stable. Raise ex_ready with a new id_valid → handoff and accept on the same edge; the next result appears the following cycle with no bubble.
- flush and async reset:
  - flush while FULL, with id_valid = 1 → next cycle ex_valid = 0 and the new instruction is not taken.
  - rst_n low mid-FULL → ex_valid = 0 and alu_op = 0000 immediately, without waiting for a clock edge.
